ahb3lite_timer: RTL and testbench
=================================

// Module: ahb3lite_timer
// PURPOSE
//  AHB3-Lite slave timer peripheral on an interconnect slave port next to the
//  CORDIC and SRAM slaves, clocked by the 10 MHz system clock.
//  Provides a prescaled 32-bit up-counter with compare match, one-shot or
//  periodic mode, a sticky match flag and a level interrupt to the core irq_i.
//  Zero-wait-state, always-OKAY slave.
// PARAMETERS
//  HADDR_SIZE  32  AHB address width
//  HDATA_SIZE  32  AHB data width; only 32 is supported
//  PRESCALE_W  16  prescaler register/counter width
// PORTS
//  hclk_i       in   1           system clock
//  hreset_n_i   in   1           async active-low reset
//  hsel_i       in   1           slave select from interconnect
//  haddr_i      in   HADDR_SIZE  address; only haddr_i[4:0] decoded
//  hwdata_i     in   HDATA_SIZE  write data (data phase)
//  hrdata_o     out  HDATA_SIZE  read data (data phase)
//  hwrite_i     in   1           1=write
//  hsize_i      in   3           0=byte 1=half 2=word
//  hburst_i     in   3           ignored
//  hprot_i      in   4           ignored
//  htrans_i     in   2           IDLE/BUSY ignored; NONSEQ/SEQ accepted
//  hreadyout_o  out  1           always 1 (zero wait)
//  hready_i     in   1           bus hready
//  hresp_o      out  1           always 0 (OKAY)
//  irq_o        out  1           match_flag & CTRL.irq_en
// BEHAVIOUR
//  Register map (haddr_i[4:2]); reset value 0 for all:
//   0x00 CTRL rw [0]enable [1]irq_en [2]oneshot; [31:3] read 0
//   0x04 PRESCALE rw [PRESCALE_W-1:0]
//   0x08 COMPARE rw 32b
//   0x0C COUNT rw 32b
//   0x10 STATUS [0]match_flag; write 1 clears, write 0 no effect
//   0x14-0x1C read 0, writes ignored, still OKAY
//  Address phase is accepted when hsel_i & hready_i & htrans_i[1]. On that
//  edge, register haddr[4:0], hwrite, hsize and the valid bit. Otherwise valid=0.
//  Write: in the following data phase, byte lanes come from the registered
//   hsize/haddr[1:0]: byte=1 lane, half=2 lanes (haddr[1] selects), word=4.
//   Registers update on the edge ending the data phase.
//  Read: hrdata_o is combinational from the registered address in the data phase
//   (current register value). hrdata_o=0 when no valid read is in data phase.
//  Back-to-back transfers are supported. A read immediately after a write to the
//   same register returns the new value.
//  Prescaler: when enable=1, pcnt increments each clock. tick=(pcnt==PRESCALE),
//   and pcnt returns to 0 on tick. PRESCALE=0 gives tick every clock.
//  Counter, on tick: if COUNT==COMPARE then COUNT<=0, match_flag<=1, and
//   enable<=0 if oneshot. Else COUNT<=COUNT+1 (wraps 0xFFFFFFFF->0, no flag).
//   COMPARE=0 gives a match on every tick.
//  enable=0: pcnt and COUNT hold. Enabling again resumes from the held values.
//  Priority / simultaneous events:
//   - HW match set beats a same-cycle STATUS W1C; flag stays 1.
//   - A bus write to COUNT beats a same-cycle tick update; pcnt<=0 too.
//   - A bus write to CTRL beats a same-cycle oneshot auto-clear of enable.
//   - A PRESCALE write takes effect on the next compare; pcnt is not reset.
//  Reset asserted mid-operation: all registers, pcnt, the data-phase state and
//   irq_o go to 0 asynchronously. hreadyout_o=1 and hresp_o=0 during reset.
// TESTING
//  1 Reset: read all 8 offsets -> 0; hreadyout_o=1, hresp_o=0, irq_o=0.
//  2 PRESCALE=9, COMPARE=4, CTRL=0x3 -> match_flag and irq_o rise at 50 clks
//    after enable; periodic repeat every 50; COUNT reads 0..4.
//  3 Oneshot: CTRL=0x7, PRESCALE=0, COMPARE=3 -> flag after 4 clks, CTRL reads
//    0x6, COUNT holds 0; W1C STATUS -> irq_o=0.
//  4 Byte lanes: word write 0x11223344 to COMPARE, then byte write 0xAA at
//    0x09 -> COMPARE=0x1122AA44; half write at 0x0A -> upper 16 bits only.
//  5 Collisions: W1C on the match cycle -> flag stays 1. COUNT=0x10 write on a
//    tick cycle -> COUNT=0x10. COUNT=0xFFFFFFFF, COMPARE=5 -> wraps to 0, no flag.
//  6 Back-to-back write COMPARE then read COMPARE with no idle -> new value.
//    Reset pulse mid-count -> all regs 0.

Source files
------------

// File: rtl/ahb3lite_timer.sv
// ahb3lite_timer: zero-wait AHB3-Lite slave holding a prescaled 32-bit
// up-counter with compare match, one-shot/periodic mode, a sticky match
// flag and a level interrupt (match_flag & irq_en).
`timescale 1ns/1ps
module ahb3lite_timer #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic                  hclk_i,
    input  logic                  hreset_n_i,
    input  logic                  hsel_i,
    input  logic [HADDR_SIZE-1:0] haddr_i,
    input  logic [HDATA_SIZE-1:0] hwdata_i,
    output logic [HDATA_SIZE-1:0] hrdata_o,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [3:0]            hprot_i,
    input  logic [1:0]            htrans_i,
    output logic                  hreadyout_o,
    input  logic                  hready_i,
    output logic                  hresp_o,
    output logic                  irq_o
);

    // Register offsets as decoded from haddr[4:2]
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    // Byte-lane enables for a write of the given size at the given low address
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << addr;
            3'd1:    m = addr[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replace only the enabled byte lanes of the old value with write data
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                r[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                r[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return r;
    endfunction

    // Data-phase state captured from the accepted address phase
    logic                  dp_valid_q;
    logic                  dp_write_q;
    logic [4:0]            dp_addr_q;
    logic [2:0]            dp_size_q;

    // Architectural registers and prescaler
    logic [2:0]            ctrl_q,     ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           compare_q,  compare_d;
    logic [31:0]           count_q,    count_d;
    logic                  flag_q,     flag_d;
    logic [PRESCALE_W-1:0] pcnt_q,     pcnt_d;

    logic                  accept_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [3:0]            mask_s;
    logic                  tick_s;
    logic                  hit_s;
    logic [31:0]           reg_sel_s;
    logic [31:0]           wmerge_s;
    logic                  unused_s;

    assign accept_s = hsel_i & hready_i & htrans_i[1];
    assign wr_s     = dp_valid_q & dp_write_q;
    assign rd_s     = dp_valid_q & ~dp_write_q;
    assign mask_s   = lane_mask(dp_size_q, dp_addr_q[1:0]);
    assign tick_s   = ctrl_q[0] & (pcnt_q == prescale_q);
    assign hit_s    = tick_s & (count_q == compare_q);
    assign wmerge_s = merge_lanes(reg_sel_s, hwdata_i[31:0], mask_s);

    assign hreadyout_o = 1'b1;
    assign hresp_o     = 1'b0;
    assign irq_o       = flag_q & ctrl_q[1];

    // Address bits above the map, burst/protection info and the SEQ/NONSEQ
    // distinction carry no meaning for this slave
    assign unused_s = ^{haddr_i[HADDR_SIZE-1:5], hburst_i, hprot_i, htrans_i[0]};

    // Select the register addressed by the data phase (shared by read and write merge)
    always_comb begin
        reg_sel_s = 32'd0;
        case (dp_addr_q[4:2])
            OFF_CTRL:     reg_sel_s = {29'd0, ctrl_q};
            OFF_PRESCALE: reg_sel_s = {{(32-PRESCALE_W){1'b0}}, prescale_q};
            OFF_COMPARE:  reg_sel_s = compare_q;
            OFF_COUNT:    reg_sel_s = count_q;
            OFF_STATUS:   reg_sel_s = {31'd0, flag_q};
            default:      reg_sel_s = 32'd0;
        endcase
    end

    // Read data is driven only while a read is in its data phase
    always_comb begin
        if (rd_s) begin
            hrdata_o = reg_sel_s;
        end else begin
            hrdata_o = 32'd0;
        end
    end

    // Next-state of timer and registers; bus writes override the timer update
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        flag_d     = flag_q;
        pcnt_d     = pcnt_q;

        // Prescaler advances only while enabled and wraps on tick
        if (ctrl_q[0]) begin
            if (tick_s) begin
                pcnt_d = {PRESCALE_W{1'b0}};
            end else begin
                pcnt_d = pcnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pcnt_d = pcnt_q;
        end

        // Counter step on tick; a match restarts from zero and may stop a one-shot
        if (hit_s) begin
            count_d = 32'd0;
            if (ctrl_q[2]) begin
                ctrl_d[0] = 1'b0;
            end else begin
                ctrl_d[0] = ctrl_q[0];
            end
        end else if (tick_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        // Hardware set of the flag wins over a simultaneous write-one-to-clear
        if (hit_s) begin
            flag_d = 1'b1;
        end else if (wr_s && (dp_addr_q[4:2] == OFF_STATUS) && mask_s[0] && hwdata_i[0]) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end

        // Bus writes take precedence over the timer for CTRL and COUNT
        if (wr_s) begin
            case (dp_addr_q[4:2])
                OFF_CTRL:     ctrl_d     = wmerge_s[2:0];
                OFF_PRESCALE: prescale_d = wmerge_s[PRESCALE_W-1:0];
                OFF_COMPARE:  compare_d  = wmerge_s;
                OFF_COUNT: begin
                    count_d = wmerge_s;
                    pcnt_d  = {PRESCALE_W{1'b0}};
                end
                default: begin
                    ctrl_d = ctrl_d;
                end
            endcase
        end else begin
            ctrl_d = ctrl_d;
        end
    end

    // Capture the accepted address phase for use in the following data phase
    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 5'd0;
            dp_size_q  <= 3'd0;
        end else begin
            dp_valid_q <= accept_s;
            dp_write_q <= hwrite_i;
            dp_addr_q  <= haddr_i[4:0];
            dp_size_q  <= hsize_i;
        end
    end

    // Timer and register state
    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            ctrl_q     <= 3'd0;
            prescale_q <= {PRESCALE_W{1'b0}};
            compare_q  <= 32'd0;
            count_q    <= 32'd0;
            flag_q     <= 1'b0;
            pcnt_q     <= {PRESCALE_W{1'b0}};
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            flag_q     <= flag_d;
            pcnt_q     <= pcnt_d;
        end
    end

endmodule

// File: tb/tb_ahb3lite_timer.sv
// Directed bench for ahb3lite_timer with a cycle-level reference model of the
// register map and timer, compared on every negative clock edge.
`timescale 1ns/1ps
module tb_ahb3lite_timer;

    logic        hclk;
    logic        hreset_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hreadyout;
    logic        hready;
    logic        hresp;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit [2:0]  m_ctrl;
    bit [15:0] m_pre;
    bit [31:0] m_cmp;
    bit [31:0] m_cnt;
    bit        m_flag;
    bit [15:0] m_pcnt;
    bit        m_dpv;
    bit        m_dpw;
    bit [4:0]  m_dpa;
    bit [2:0]  m_dps;

    logic [31:0] pend_wdata;
    logic [31:0] rd;

    ahb3lite_timer #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PRESCALE_W(16)) dut (
        .hclk_i      (hclk),
        .hreset_n_i  (hreset_n),
        .hsel_i      (hsel),
        .haddr_i     (haddr),
        .hwdata_i    (hwdata),
        .hrdata_o    (hrdata),
        .hwrite_i    (hwrite),
        .hsize_i     (hsize),
        .hburst_i    (hburst),
        .hprot_i     (hprot),
        .htrans_i    (htrans),
        .hreadyout_o (hreadyout),
        .hready_i    (hready),
        .hresp_o     (hresp),
        .irq_o       (irq)
    );

    initial hclk = 1'b0;
    always #50 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_read(input bit [2:0] off);
        case (off)
            3'd0:    return {29'd0, m_ctrl};
            3'd1:    return {16'd0, m_pre};
            3'd2:    return m_cmp;
            3'd3:    return m_cnt;
            3'd4:    return {31'd0, m_flag};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 3'd0; m_pre = 16'd0; m_cmp = 32'd0; m_cnt = 32'd0;
        m_flag = 1'b0; m_pcnt = 16'd0;
        m_dpv = 1'b0; m_dpw = 1'b0; m_dpa = 5'd0; m_dps = 3'd0;
    endtask

    // One clock of the timer peripheral, expressed from the register-map rules
    task automatic model_step();
        bit        tick, hit;
        bit [2:0]  nctrl;
        bit [15:0] npre, npcnt;
        bit [31:0] ncmp, ncnt, wv;
        bit        nflag;
        int        lo, n;
        tick  = m_ctrl[0] && (m_pcnt == m_pre);
        hit   = tick && (m_cnt == m_cmp);
        nctrl = m_ctrl; npre = m_pre; ncmp = m_cmp; ncnt = m_cnt;
        nflag = m_flag; npcnt = m_pcnt;
        if (m_ctrl[0]) npcnt = tick ? 16'd0 : m_pcnt + 16'd1;
        if (hit) begin
            ncnt  = 32'd0;
            nflag = 1'b1;
            if (m_ctrl[2]) nctrl[0] = 1'b0;
        end else if (tick) begin
            ncnt = m_cnt + 32'd1;
        end
        if (m_dpv && m_dpw) begin
            case (m_dps)
                3'd0:    begin lo = int'(m_dpa[1:0]);     n = 1; end
                3'd1:    begin lo = m_dpa[1] ? 2 : 0;     n = 2; end
                default: begin lo = 0;                    n = 4; end
            endcase
            wv = model_read(m_dpa[4:2]);
            for (int b = lo; b < lo + n; b++) wv[8*b +: 8] = hwdata[8*b +: 8];
            case (m_dpa[4:2])
                3'd0: nctrl = wv[2:0];
                3'd1: npre  = wv[15:0];
                3'd2: ncmp  = wv;
                3'd3: begin ncnt = wv; npcnt = 16'd0; end
                3'd4: if (lo == 0 && hwdata[0] && !hit) nflag = 1'b0;
                default: ;
            endcase
        end
        m_ctrl = nctrl; m_pre = npre; m_cmp = ncmp; m_cnt = ncnt;
        m_flag = nflag; m_pcnt = npcnt;
        m_dpv = hsel && hready && htrans[1];
        m_dpw = hwrite;
        m_dpa = haddr[4:0];
        m_dps = hsize;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge hclk);
            if (!hreset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge hreset_n);
            model_reset();
        end
    end

    // Compare DUT outputs with the model on every falling clock edge
    initial begin
        forever begin
            @(negedge hclk);
            check("hreadyout", {31'd0, hreadyout}, 32'd1);
            check("hresp", {31'd0, hresp}, 32'd0);
            if (!hreset_n) begin
                check("irq_in_reset", {31'd0, irq}, 32'd0);
            end else begin
                check("irq_model", {31'd0, irq}, {31'd0, m_flag & m_ctrl[1]});
                check("hrdata_model", hrdata,
                      (m_dpv && !m_dpw) ? model_read(m_dpa[4:2]) : 32'd0);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus clock: data for the previous phase, new address phase, then wait an edge
    task automatic bus_cycle(input bit act, input bit wr, input logic [4:0] a,
                             input logic [2:0] sz, input logic [31:0] wd);
        hwdata = pend_wdata;
        hsel   = act;
        htrans = act ? 2'b10 : 2'b00;
        haddr  = {27'd0, a};
        hwrite = wr;
        hsize  = sz;
        pend_wdata = wd;
        @(posedge hclk); #1;
    endtask

    task automatic wr32(input logic [4:0] a, input logic [2:0] sz, input logic [31:0] d);
        bus_cycle(1'b1, 1'b1, a, sz, d);
        bus_cycle(1'b0, 1'b0, 5'd0, 3'd0, 32'd0);
    endtask

    task automatic rd32(input logic [4:0] a, output logic [31:0] d);
        bus_cycle(1'b1, 1'b0, a, 3'd2, 32'd0);
        hwdata = pend_wdata;
        hsel   = 1'b0;
        htrans = 2'b00;
        @(negedge hclk);
        d = hrdata;
        @(posedge hclk); #1;
    endtask

    task automatic expect_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd32(a, d);
        check(name, d, exp);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset_n = 1'b0; hsel = 1'b0; haddr = 32'd0; hwdata = 32'd0; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; htrans = 2'b00; hready = 1'b1;
        pend_wdata = 32'd0;
        repeat (3) @(posedge hclk);
        #20 hreset_n = 1'b1;
        @(posedge hclk); #1;

        // 1: reset values
        check("reset_hreadyout", {31'd0, hreadyout}, 32'd1);
        check("reset_hresp", {31'd0, hresp}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 8; i++) expect_rd("reset_read", 5'(i * 4), 32'd0);

        // 2: periodic, PRESCALE=9 COMPARE=4 -> match every 50 clocks
        wr32(5'h04, 3'd2, 32'd9);
        wr32(5'h08, 3'd2, 32'd4);
        wr32(5'h00, 3'd2, 32'h3);
        clocks(49);
        check("periodic_before_match", {31'd0, irq}, 32'd0);
        clocks(1);
        check("periodic_first_match", {31'd0, irq}, 32'd1);
        wr32(5'h10, 3'd2, 32'd1);
        check("periodic_w1c", {31'd0, irq}, 32'd0);
        clocks(47);
        check("periodic_before_second", {31'd0, irq}, 32'd0);
        clocks(1);
        check("periodic_second_match", {31'd0, irq}, 32'd1);
        expect_rd("periodic_count0", 5'h0C, 32'd0);
        clocks(30);
        expect_rd("periodic_count3", 5'h0C, 32'd3);
        wr32(5'h00, 3'd2, 32'h0);

        // 3: one-shot with PRESCALE=0 COMPARE=3
        wr32(5'h0C, 3'd2, 32'd0);
        wr32(5'h04, 3'd2, 32'd0);
        wr32(5'h08, 3'd2, 32'd3);
        wr32(5'h10, 3'd2, 32'd1);
        wr32(5'h00, 3'd2, 32'h7);
        clocks(3);
        check("oneshot_before", {31'd0, irq}, 32'd0);
        clocks(1);
        check("oneshot_match", {31'd0, irq}, 32'd1);
        expect_rd("oneshot_ctrl", 5'h00, 32'h6);
        clocks(5);
        expect_rd("oneshot_count_hold", 5'h0C, 32'd0);
        expect_rd("oneshot_status", 5'h10, 32'd1);
        wr32(5'h10, 3'd2, 32'd1);
        check("oneshot_w1c_irq", {31'd0, irq}, 32'd0);

        // 4: byte lanes
        wr32(5'h08, 3'd2, 32'h11223344);
        expect_rd("lane_word", 5'h08, 32'h11223344);
        wr32(5'h09, 3'd0, 32'h0000AA00);
        expect_rd("lane_byte", 5'h08, 32'h1122AA44);
        wr32(5'h0A, 3'd1, 32'hBEEF0000);
        expect_rd("lane_half", 5'h08, 32'hBEEFAA44);

        // 5a: W1C landing on the match edge leaves the flag set
        wr32(5'h08, 3'd2, 32'd3);
        wr32(5'h00, 3'd2, 32'h3);
        clocks(2);
        wr32(5'h10, 3'd2, 32'd1);
        check("collide_w1c_vs_match", {31'd0, irq}, 32'd1);

        // 5b: COUNT write on a tick edge wins, then one more tick
        bus_cycle(1'b1, 1'b1, 5'h0C, 3'd2, 32'h10);
        bus_cycle(1'b1, 1'b1, 5'h00, 3'd2, 32'h0);
        bus_cycle(1'b0, 1'b0, 5'd0, 3'd0, 32'd0);
        expect_rd("collide_count_write", 5'h0C, 32'h11);

        // 5c: wrap from 0xFFFFFFFF without a match
        wr32(5'h10, 3'd2, 32'd1);
        wr32(5'h08, 3'd2, 32'd5);
        bus_cycle(1'b1, 1'b1, 5'h0C, 3'd2, 32'hFFFFFFFF);
        bus_cycle(1'b1, 1'b1, 5'h00, 3'd2, 32'h1);
        bus_cycle(1'b1, 1'b1, 5'h00, 3'd2, 32'h0);
        bus_cycle(1'b0, 1'b0, 5'd0, 3'd0, 32'd0);
        expect_rd("wrap_count", 5'h0C, 32'd0);
        expect_rd("wrap_no_flag", 5'h10, 32'd0);

        // 6: back-to-back write then read of COMPARE
        bus_cycle(1'b1, 1'b1, 5'h08, 3'd2, 32'hCAFEF00D);
        expect_rd("b2b_compare", 5'h08, 32'hCAFEF00D);

        // 6: reset pulse while counting with a pending interrupt
        wr32(5'h08, 3'd2, 32'd2);
        wr32(5'h0C, 3'd2, 32'd0);
        wr32(5'h00, 3'd2, 32'h3);
        clocks(10);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        #20 hreset_n = 1'b0;
        #10;
        check("mid_reset_irq", {31'd0, irq}, 32'd0);
        check("mid_reset_hreadyout", {31'd0, hreadyout}, 32'd1);
        check("mid_reset_hresp", {31'd0, hresp}, 32'd0);
        @(posedge hclk);
        @(posedge hclk);
        #20 hreset_n = 1'b1;
        @(posedge hclk); #1;
        for (int i = 0; i < 8; i++) expect_rd("post_reset_read", 5'(i * 4), 32'd0);
        clocks(5);
        check("post_reset_irq", {31'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
